// File: rtl/control_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_mc
// Brief    : Multi-cycle control unit. Decodes single-cycle instructions,
//            sequences DELAY and HD->MI transfers, halts, and preempts a
//            user process when its quantum expires.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit_mc #(
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 16,
  parameter int XA_W     = 6,
  parameter int XFER_LEN = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                interruption,
  input  logic                flagJB,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [CNT_W-1:0]    operand,
  output logic [2:0]          flagPC,
  output logic                flagRF,
  output logic [2:0]          flagMuxRF,
  output logic                flagMD,
  output logic                flagMI,
  output logic [XA_W-1:0]     xferAddr,
  output logic                flagHALT,
  output logic                flagCS,
  output logic                busy,
  output logic                mpActive
);

  localparam logic [OPCODE_W-1:0] OP_ALU   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LI    = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_BNQ   = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_JR    = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_HLT   = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_IN    = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_OUT   = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_DELAY = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_HDT   = OPCODE_W'(15);
  localparam logic [OPCODE_W-1:0] OP_SMP   = OPCODE_W'(20);
  localparam logic [OPCODE_W-1:0] OP_SQ    = OPCODE_W'(21);
  localparam logic [OPCODE_W-1:0] OP_S22   = OPCODE_W'(22);
  localparam logic [OPCODE_W-1:0] OP_S23   = OPCODE_W'(23);
  localparam logic [OPCODE_W-1:0] OP_EXEC  = OPCODE_W'(24);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XA_W-1:0]  XA_ONE   = XA_W'(1);
  localparam int               XFER_LAST_I = XFER_LEN - 1;
  localparam logic [XA_W-1:0]  XA_LAST  = XA_W'(XFER_LAST_I);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_DLY  = 2'd1,
    S_XFER = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  dcnt;
  logic [XA_W-1:0]   xfer_addr;
  logic [CNT_W-1:0]  quantum;
  logic [CNT_W-1:0]  qcnt;
  logic              mp_en;
  logic              user_mode;
  logic              cs_pending;

  // Action strobes from the decoder, already qualified by reset/interruption
  logic ld_dly, ld_xfer, ld_quantum, ld_mp, do_exec, do_cs;
  logic mp_active;

  assign mp_active = mp_en & user_mode;
  assign mpActive  = ~reset & mp_active;
  assign busy      = ~reset & ((state == S_DLY) | (state == S_XFER));
  assign xferAddr  = reset ? '0 : xfer_addr;

  // Next-state, decoded control outputs and register-update strobes
  always_comb begin
    state_next = state;
    flagPC     = 3'd0;
    flagRF     = 1'b0;
    flagMuxRF  = 3'd0;
    flagMD     = 1'b0;
    flagMI     = 1'b0;
    flagHALT   = 1'b0;
    flagCS     = 1'b0;
    ld_dly     = 1'b0;
    ld_xfer    = 1'b0;
    ld_quantum = 1'b0;
    ld_mp      = 1'b0;
    do_exec    = 1'b0;
    do_cs      = 1'b0;
    if (!reset && !interruption) begin
      case (state)
        S_RUN: begin
          if (cs_pending) begin
            // Preemption wins over whatever instruction is presented
            flagCS = 1'b1;
            flagPC = 3'd2;
            do_cs  = 1'b1;
          end else begin
            case (opcode)
              OP_ALU: begin flagRF = 1'b1; flagMuxRF = 3'd1; flagPC = 3'd1; end
              OP_LW:  begin flagRF = 1'b1; flagMuxRF = 3'd2; flagPC = 3'd1; end
              OP_LI:  begin flagRF = 1'b1; flagMuxRF = 3'd4; flagPC = 3'd1; end
              OP_IN:  begin flagRF = 1'b1; flagMuxRF = 3'd3; flagPC = 3'd1; end
              OP_SW:  begin flagMD = 1'b1; flagPC = 3'd1; end
              OP_BEQ, OP_BNQ: flagPC = flagJB ? 3'd2 : 3'd1;
              OP_JMP, OP_JR:  flagPC = 3'd2;
              OP_NOP, OP_OUT, OP_S22, OP_S23: flagPC = 3'd1;
              OP_SMP: begin flagPC = 3'd1; ld_mp = 1'b1; end
              OP_SQ:  begin flagPC = 3'd1; ld_quantum = 1'b1; end
              OP_EXEC: begin flagPC = 3'd2; do_exec = 1'b1; end
              OP_HLT: state_next = S_HALT;
              OP_DELAY: begin
                if (operand == '0) begin
                  flagPC = 3'd1;
                end else begin
                  ld_dly     = 1'b1;
                  state_next = S_DLY;
                end
              end
              OP_HDT: begin
                ld_xfer    = 1'b1;
                state_next = S_XFER;
              end
              default: ;
            endcase
          end
        end
        S_DLY: begin
          if (dcnt == CNT_ONE) begin
            flagPC     = 3'd1;
            state_next = S_RUN;
          end
        end
        S_XFER: begin
          flagMI = 1'b1;
          if (xfer_addr == XA_LAST) begin
            flagPC     = 3'd1;
            state_next = S_RUN;
          end
        end
        S_HALT: flagHALT = 1'b1;
        default: state_next = S_RUN;
      endcase
    end
  end

  // State and datapath registers; interruption freezes everything
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_RUN;
      dcnt       <= '0;
      xfer_addr  <= '0;
      quantum    <= '0;
      qcnt       <= '0;
      mp_en      <= 1'b0;
      user_mode  <= 1'b0;
      cs_pending <= 1'b0;
    end else if (!interruption) begin
      state <= state_next;
      if (ld_dly)
        dcnt <= operand;
      else if (state == S_DLY)
        dcnt <= dcnt - CNT_ONE;
      if (ld_xfer)
        xfer_addr <= '0;
      else if (state == S_XFER)
        xfer_addr <= xfer_addr + XA_ONE;
      if (ld_quantum)
        quantum <= operand;
      if (ld_mp)
        mp_en <= operand[0];
      if (do_exec) begin
        user_mode  <= 1'b1;
        qcnt       <= quantum;
        cs_pending <= 1'b0;
      end else begin
        // Taking the switch clears the request; otherwise expiry raises it
        if (do_cs) begin
          cs_pending <= 1'b0;
          user_mode  <= 1'b0;
        end else if (mp_active && qcnt == '0) begin
          cs_pending <= 1'b1;
        end
        if (mp_active && state != S_HALT && qcnt != '0)
          qcnt <= qcnt - CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/control_unit_mc.md
CONTROL_UNIT_MC -- requirements
Module: control_unit_mc

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- OPCODE_W, 6, opcode width.
- CNT_W, 16, width of the delay, quantum and operand fields.
- XA_W, 6, transfer address width.
- XFER_LEN, 64, words per HD->MI transfer; valid range 1..2^XA_W.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, sole clock.
- reset, in, 1, synchronous, active-high.
- interruption, in, 1, freeze.
- flagJB, in, 1, branch condition.
- opcode, in, OPCODE_W, current instruction.
- operand, in, CNT_W, immediate for DELAY/SET_*.
- flagPC, out, 3, 0 = hold, 1 = PC+1, 2 = load target.
- flagRF, out, 1, register-file write.
- flagMuxRF, out, 3, RF data select.
- flagMD, out, 1, data-memory write.
- flagMI, out, 1, instruction-memory write.
- xferAddr, out, XA_W, MI write address.
- flagHALT, out, 1, halted.
- flagCS, out, 1, context switch.
- busy, out, 1, multi-cycle instruction in progress.
- mpActive, out, 1, user process running under quantum.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high; all state SHALL update on the rising edge of clock.

Function
REQ-004 FSM states SHALL be RUN, DLY, XFER, HALT; busy = (state is DLY or XFER).
REQ-005 Registers SHALL be: state, dcnt[CNT_W], xferAddr, quantum[CNT_W], qcnt[CNT_W], mpEn, userMode, csPending.
REQ-006 Outputs SHALL be combinational from state, opcode, flagJB and csPending; any output not listed for a case SHALL be 0.
REQ-007 RUN with csPending=0 SHALL decode opcode as follows:
- 0 ALU: RF=1, Mux=1, PC=1.
- 1 LW: RF=1, Mux=2, PC=1.
- 2 LI: RF=1, Mux=4, PC=1.
- 4 SW: MD=1, PC=1.
- 6 BEQ / 7 BNQ: PC = flagJB ? 2 : 1.
- 8 JMP / 9 JR: PC=2.
- 10 NOP / 13 OUT / 20-23 SET_*: PC=1.
- 12 IN: RF=1, Mux=3, PC=1.
- 24 EXEC_PROCESS: PC=2.
- Unlisted opcodes: all outputs 0 (PC=0).
REQ-008 DELAY (14) in RUN:
- operand=0: PC=1, stay RUN.
- Otherwise: PC=0, dcnt<=operand, go DLY.
REQ-009 DLY SHALL decrement dcnt each cycle; when dcnt==1, PC=1 and next state RUN. DELAY N therefore takes N+1 cycles.
REQ-010 HD_TRANSFER_MI (15) in RUN SHALL output PC=0, set xferAddr<=0 and go XFER.
REQ-011 XFER SHALL assert flagMI=1 and increment xferAddr each cycle; when xferAddr==XFER_LEN-1, PC=1 and next state RUN. This gives exactly XFER_LEN write cycles with addresses 0..XFER_LEN-1.
REQ-012 HLT (11) in RUN SHALL go to HALT. HALT SHALL output flagHALT=1 with PC=0, and SHALL be left only by reset.
REQ-013 SET_QUANTUM (21) SHALL load quantum<=operand. SET_MULTIPROG (20) SHALL load mpEn<=operand[0].
REQ-014 EXEC_PROCESS SHALL set userMode<=1, qcnt<=quantum and csPending<=0.
REQ-015 mpActive SHALL equal mpEn & userMode.
REQ-016 While mpActive=1, interruption=0, state!=HALT and qcnt!=0, qcnt SHALL decrement every cycle.
REQ-017 When qcnt==0 and mpActive=1, csPending SHALL be set on the next edge. A quantum of 0 therefore sets csPending one cycle after EXEC_PROCESS.
REQ-018 RUN with csPending=1 SHALL suppress the decode and output flagCS=1, PC=2, all other outputs 0, for one cycle; it SHALL then clear csPending and userMode.
REQ-019 Expiry during DLY or XFER SHALL complete the multi-cycle instruction first; the context switch SHALL be taken on the first RUN cycle after it.
REQ-020 csPending in RUN SHALL take priority over any opcode, including HLT, DELAY and HD_TRANSFER_MI; the suppressed instruction SHALL not be executed.
REQ-021 While interruption=1:
- All outputs except xferAddr, busy and mpActive SHALL be 0.
- No register SHALL change.
- Operation SHALL resume unchanged the cycle after deassertion.
REQ-022 opcode SHALL be ignored in DLY, XFER and HALT.

Reset
REQ-023 With reset=1 at an edge, the following SHALL be cleared, from any state including mid-DLY or mid-XFER:
- state <= RUN.
- dcnt, xferAddr, quantum, qcnt <= 0.
- mpEn, userMode, csPending <= 0.
REQ-024 reset SHALL take priority over interruption. While reset=1, all outputs SHALL be 0.

Verification
REQ-025 DELAY with operand=3 -> flagPC sequence 0,0,0,1 over 4 cycles, then RUN; operand=0 -> single cycle with flagPC=1.
REQ-026 HD_TRANSFER_MI with XFER_LEN=4 -> issue cycle flagPC=0, then flagMI=1 with xferAddr 0,1,2,3, flagPC=1 on address 3, busy=1 for those 4 cycles.
REQ-027 SET_QUANTUM 5, SET_MULTIPROG 1, EXEC_PROCESS, then NOP stream -> qcnt reaches 0 five cycles after EXEC_PROCESS; flagCS=1, flagPC=2 on the next RUN cycle; mpActive=0 afterwards.
REQ-028 Quantum expires during DELAY 10 -> no flagCS until the DELAY completes; flagCS on the first RUN cycle. HLT presented on that cycle -> flagHALT stays 0.
REQ-029 interruption held 3 cycles mid-XFER at xferAddr=2 -> flagMI=0 and xferAddr=2 throughout; resumes at address 2. Reset mid-DLY -> RUN, all outputs 0.
REQ-030 BEQ with flagJB=1 -> flagPC=2; with flagJB=0 -> flagPC=1; opcode 63 -> all outputs 0.
